mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares one combinational Q-format multiplier (multiplier_16bit) between NUM_REQ requesters in the ODE solver datapath, e.g. step-size scaling and derivative-term units. It accepts operand pairs over a valid/ready handshake. It drives the multiplier for one evaluation cycle, registers the result and overflow flag, and returns them to the granted requester.

---
 rtl/mult_share_arbiter_pkg.sv | 22 ++
 rtl/mult_share_arbiter_rr_arbiter.sv | 51 +++++
 rtl/mult_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: Q-format field
// positions, default data width, FSM state encoding and index-width helper.
package mult_share_arbiter_pkg;

  // Q-format layout: [15:13] scale factor, [12:0] signed number
  localparam int SCALE_MSB  = 15;
  localparam int SCALE_LSB  = 13;
  localparam int NUM_MSB    = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of a requester index; never below one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches requesters starting one above
// last_grant and wrapping, returning a one-hot grant and its index.
module rr_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  localparam logic [IDX_W:0] NUM_REQ_L = (IDX_W+1)'(NUM_REQ);

  // cand_idx[k] is the requester examined at search offset k+1
  logic [IDX_W-1:0] cand_idx [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gen_cand
      localparam logic [IDX_W:0] OFFSET = (IDX_W+1)'(gi + 1);
      logic [IDX_W:0] sum;
      logic [IDX_W:0] wrapped;
      assign sum          = {1'b0, last_grant} + OFFSET;
      assign wrapped      = (sum >= NUM_REQ_L) ? (sum - NUM_REQ_L) : sum;
      assign cand_idx[gi] = wrapped[IDX_W-1:0];
    end
  endgenerate

  // Nearest valid requester after last_grant wins (lowest offset last to assign)
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        grant_idx   = cand_idx[k];
        grant_valid = 1'b1;
      end
    end
  end

  // Expand the winning index to a one-hot vector
  always_comb begin
    grant = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one external combinational Q-format multiplier between
// NUM_REQ requesters. Accepts an operand pair, evaluates for one cycle,
// holds the registered product until the consumer takes it.
// Optional build macro: MULT_SHARE_STICKY_OVF_EN (sticky per-requester
// overflow flags on ovf_status, cleared through ovf_clear).
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_overflow,
  output logic [DATA_W-1:0]         mult_a,
  output logic [DATA_W-1:0]         mult_b,
  output logic                      mult_enable,
  input  logic [DATA_W-1:0]         mult_out,
  input  logic                      mult_overflow,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        ovf_status,
  input  logic [NUM_REQ-1:0]        ovf_clear
);

  localparam int               IDX_W    = idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   last_grant_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic [DATA_W-1:0]  op_a_reg;
  logic [DATA_W-1:0]  op_b_reg;
  logic [DATA_W-1:0]  resp_data_reg;
  logic               resp_overflow_reg;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   arb_ptr;
  logic               arb_valid;
  logic               resp_done;
  logic               accept;

  logic [DATA_W-1:0]  a_arr [NUM_REQ];
  logic [DATA_W-1:0]  b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gen_unpack
      assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A completing response advances the pointer in the same cycle, so a
  // back-to-back arbitration already sees the just-served requester as last.
  assign resp_done = (state_reg == RESP) && resp_ready;
  assign arb_ptr   = (state_reg == RESP) ? grant_reg : last_grant_reg;
  assign accept    = arb_valid && ((state_reg == IDLE) || resp_done);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .last_grant  (arb_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Sequencer: accept -> one evaluation cycle -> hold response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      last_grant_reg    <= LAST_RST;
      grant_reg         <= '0;
      op_a_reg          <= '0;
      op_b_reg          <= '0;
      resp_data_reg     <= '0;
      resp_overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_a_reg  <= a_arr[arb_idx];
            op_b_reg  <= b_arr[arb_idx];
            grant_reg <= arb_idx;
            state_reg <= CALC;
          end
        end
        CALC: begin
          resp_data_reg     <= mult_out;
          resp_overflow_reg <= mult_overflow;
          state_reg         <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            last_grant_reg <= grant_reg;
            if (accept) begin
              op_a_reg  <= a_arr[arb_idx];
              op_b_reg  <= b_arr[arb_idx];
              grant_reg <= arb_idx;
              state_reg <= CALC;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready     = accept ? arb_grant : '0;
  assign mult_a        = op_a_reg;
  assign mult_b        = op_b_reg;
  assign mult_enable   = (state_reg == CALC);
  assign busy          = (state_reg != IDLE);
  assign resp_data     = resp_data_reg;
  assign resp_overflow = resp_overflow_reg;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gen_resp_valid
      assign resp_valid[gi] = (state_reg == RESP) && (grant_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef MULT_SHARE_STICKY_OVF_EN
  logic [NUM_REQ-1:0] ovf_status_reg;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gen_sticky
      // Set on a completed overflowing response; set beats a same-cycle clear
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_status_reg[gi] <= 1'b0;
        end else if (resp_done && resp_overflow_reg && (grant_reg == IDX_W'(gi))) begin
          ovf_status_reg[gi] <= 1'b1;
        end else if (ovf_clear[gi]) begin
          ovf_status_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign ovf_status = ovf_status_reg;
`else
  logic unused_ovf_clear;
  assign unused_ovf_clear = ^ovf_clear;
  assign ovf_status       = '0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a stand-in multiplier that
// returns the low 16 bits of the integer product and flags any high bits.
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_ready;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_overflow;
  logic [DATA_W-1:0]         mult_a;
  logic [DATA_W-1:0]         mult_b;
  logic                      mult_enable;
  logic [DATA_W-1:0]         mult_out;
  logic                      mult_overflow;
  logic                      busy;
  logic [NUM_REQ-1:0]        ovf_status;
  logic [NUM_REQ-1:0]        ovf_clear;

  logic [31:0] prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_overflow (resp_overflow),
    .mult_a        (mult_a),
    .mult_b        (mult_b),
    .mult_enable   (mult_enable),
    .mult_out      (mult_out),
    .mult_overflow (mult_overflow),
    .busy          (busy),
    .ovf_status    (ovf_status),
    .ovf_clear     (ovf_clear)
  );

  // Stand-in multiplier: output only meaningful while enabled
  always_comb begin
    prod          = {16'h0, mult_a} * {16'h0, mult_b};
    mult_out      = mult_enable ? prod[15:0] : 16'h0;
    mult_overflow = mult_enable & (|prod[31:16]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},    {31'h0, busy},          32'h0);
    chk({tag, "_rready"},  {28'h0, req_ready},     32'h0);
    chk({tag, "_rvalid"},  {28'h0, resp_valid},    32'h0);
    chk({tag, "_men"},     {31'h0, mult_enable},   32'h0);
    chk({tag, "_ma"},      {16'h0, mult_a},        32'h0);
    chk({tag, "_mb"},      {16'h0, mult_b},        32'h0);
    chk({tag, "_rdata"},   {16'h0, resp_data},     32'h0);
    chk({tag, "_rovf"},    {31'h0, resp_overflow}, 32'h0);
    chk({tag, "_ovfstat"}, {28'h0, ovf_status},    32'h0);
  endtask

  logic [3:0] exp_sticky;
  int         g;
  int         ng;

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    ovf_clear  = '0;
    tick();
    tick();
    chk_reset_outputs("reset");

    // 1: single request from requester 0, 3*5
    rst       = 1'b0;
    req_valid = 4'b0001;
    set_ops(0, 16'h0003, 16'h0005);
    settle();
    $display("t1 request 0 a=0003 b=0005");
    chk("t1_accept_ready", {28'h0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    settle();
    chk("t1_calc_en",     {31'h0, mult_enable}, 32'h1);
    chk("t1_calc_ma",     {16'h0, mult_a},      32'h3);
    chk("t1_calc_mb",     {16'h0, mult_b},      32'h5);
    chk("t1_calc_rvalid", {28'h0, resp_valid},  32'h0);
    chk("t1_calc_busy",   {31'h0, busy},        32'h1);
    tick();
    chk("t1_resp_en",     {31'h0, mult_enable}, 32'h0);
    chk("t1_resp_valid",  {28'h0, resp_valid},  32'h1);
    chk("t1_resp_data",   {16'h0, resp_data},   32'h000F);
    chk("t1_resp_ovf",    {31'h0, resp_overflow}, 32'h0);
    chk("t1_resp_ma_hold", {16'h0, mult_a},     32'h3);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    settle();
    chk("t1_idle_busy",   {31'h0, busy},        32'h0);
    chk("t1_idle_rvalid", {28'h0, resp_valid},  32'h0);

    // 2: all four valid, pointer restarted by reset; expect 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 16'(i + 1), 16'h0002);
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    settle();
    chk("t2_first_ready", {28'h0, req_ready}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      g  = k % 4;
      ng = (k + 1) % 4;
      tick();
      chk("t2_calc_en",   {31'h0, mult_enable}, 32'h1);
      chk("t2_calc_busy", {31'h0, busy},        32'h1);
      tick();
      if (k == 4) begin
        req_valid = '0;
        settle();
      end
      $display("t2 op %0d grant %0d data %0h", k, g, resp_data);
      chk("t2_resp_valid", {28'h0, resp_valid}, 32'(1 << g));
      chk("t2_resp_data",  {16'h0, resp_data},  32'((g + 1) * 2));
      chk("t2_next_ready", {28'h0, req_ready},  (k == 4) ? 32'h0 : 32'(1 << ng));
    end
    tick();
    resp_ready = 1'b0;
    chk("t2_end_idle", {31'h0, busy}, 32'h0);

    // 3: overflow from requester 2, then same-edge set and clear
    req_valid = 4'b0100;
    set_ops(2, 16'h0FFF, 16'h0FFF);
    settle();
    chk("t3_accept_ready", {28'h0, req_ready}, 32'h4);
    tick();
    req_valid = '0;
    tick();
    $display("t3 overflow response data %0h ovf %0b", resp_data, resp_overflow);
    chk("t3_resp_ovf",  {31'h0, resp_overflow}, 32'h1);
    chk("t3_resp_data", {16'h0, resp_data},     32'hE001);
`ifdef MULT_SHARE_STICKY_OVF_EN
    exp_sticky = 4'b0100;
`else
    exp_sticky = 4'b0000;
`endif
    chk("t3_sticky_before", {28'h0, ovf_status}, 32'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("t3_sticky_set", {28'h0, ovf_status}, {28'h0, exp_sticky});
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    resp_ready = 1'b1;
    ovf_clear  = 4'b0100;
    tick();
    resp_ready = 1'b0;
    ovf_clear  = '0;
    chk("t3_set_beats_clear", {28'h0, ovf_status}, {28'h0, exp_sticky});
    ovf_clear = 4'b0100;
    tick();
    ovf_clear = '0;
    chk("t3_cleared", {28'h0, ovf_status}, 32'h0);

    // 4: stall in RESP for 5 cycles with other requesters waiting
    set_ops(1, 16'h0007, 16'h0003);
    set_ops(3, 16'h0004, 16'h0004);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    tick();
    for (int s = 0; s < 5; s++) begin
      $display("t4 stall cycle %0d resp_valid %b data %0h", s, resp_valid, resp_data);
      chk("t4_stall_valid", {28'h0, resp_valid}, 32'h2);
      chk("t4_stall_data",  {16'h0, resp_data},  32'h15);
      chk("t4_stall_ready", {28'h0, req_ready},  32'h0);
      chk("t4_stall_busy",  {31'h0, busy},       32'h1);
      tick();
    end
    resp_ready = 1'b1;
    settle();
    chk("t4_release_ready", {28'h0, req_ready}, 32'h8);
    tick();
    req_valid  = '0;
    resp_ready = 1'b0;
    settle();
    chk("t4_b2b_calc",   {31'h0, mult_enable}, 32'h1);
    chk("t4_b2b_ma",     {16'h0, mult_a},      32'h4);
    chk("t4_b2b_rvalid", {28'h0, resp_valid},  32'h0);
    tick();
    chk("t4_b2b_valid",  {28'h0, resp_valid},  32'h8);
    chk("t4_b2b_data",   {16'h0, resp_data},   32'h10);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // 5: reset during CALC drops the transaction
    set_ops(2, 16'h0003, 16'h0003);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    settle();
    chk("t5_in_calc", {31'h0, mult_enable}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("t5 reset during calc");
    chk_reset_outputs("t5_after_rst");
    tick();
    chk("t5_no_resp", {28'h0, resp_valid}, 32'h0);
    req_valid = 4'b1111;
    settle();
    chk("t5_grant0", {28'h0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // 6: short pulse from requester 2 while busy is never accepted
    set_ops(0, 16'h0002, 16'h0002);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0100;
    settle();
    $display("t6 pulse on requester 2 during calc");
    chk("t6_pulse_ready", {28'h0, req_ready}, 32'h0);
    tick();
    req_valid = '0;
    settle();
    chk("t6_resp_valid", {28'h0, resp_valid}, 32'h1);
    chk("t6_resp_data",  {16'h0, resp_data},  32'h4);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("t6_idle", {31'h0, busy}, 32'h0);
    tick();
    chk("t6_still_idle",  {31'h0, busy},       32'h0);
    chk("t6_no_resp",     {28'h0, resp_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
